slow_clock_gen: RTL
===================

Name: slow_clock_gen

Overview:
- Generates a programmable slow clock waveform, clk_slow, on the fast system clock, with single-cycle rise and fall strobes aligned to its edges.
- It is the source-side counterpart of the rising-edge detector. The detector samples clk_slow on the fast clock; this block drives clk_slow from the fast clock.
- Used for NoC/peripheral tick domains: timers, low-rate serial links and throttled arbiters.
- Configuration (high/low phase lengths) is updated at runtime through a valid/ready handshake. Updates apply only on period boundaries, so no runt pulses are produced.

Parameters:
- CNT_W, 16, width of the phase-length fields and the internal phase counter.
- PCNT_W, 8, width of the period counter output.
- DEFAULT_HI, 1, high-phase length in fast cycles after reset.
- DEFAULT_LO, 1, low-phase length in fast cycles after reset.

Ports:
- clk  in  1  fast clock; all logic on posedge.
- rst_l  in  1  asynchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  configuration slot free.
- cfg_hi  in  CNT_W  high-phase length; 0 is treated as 1.
- cfg_lo  in  CNT_W  low-phase length; 0 is treated as 1.
- clk_slow  out  1  generated slow clock; registered.
- rise  out  1  one-cycle strobe in the first cycle clk_slow is high; registered.
- fall  out  1  one-cycle strobe in the first cycle clk_slow is low after a high phase; registered.
- busy  out  1  state is not IDLE.
- period_cnt  out  PCNT_W  count of rise strobes; wraps modulo 2^PCNT_W.

Behaviour:
- Reset (rst_l=0, asynchronous):
  - state=IDLE.
  - clk_slow=0, rise=0, fall=0, busy=0, period_cnt=0.
  - cfg_ready=1.
  - hi_len=DEFAULT_HI, lo_len=DEFAULT_LO.
  - Any pending configuration is discarded.
  - Reset mid-period truncates the waveform immediately, with no fall strobe.
- States: IDLE, HIGH, LOW. Phase counter pcnt is CNT_W bits and counts down.
- IDLE:
  - clk_slow=0.
  - If en=1 at edge t, then in cycle t+1: state=HIGH, clk_slow=1, rise=1, period_cnt+1, pcnt=hi_len-1.
- HIGH:
  - pcnt decrements each cycle.
  - When pcnt==0: next state=LOW, clk_slow=0, fall=1, pcnt=lo_len-1.
  - clk_slow is therefore high for exactly hi_len cycles.
- LOW:
  - pcnt decrements each cycle.
  - When pcnt==0 and en=1: apply any pending configuration, then next state=HIGH, rise=1, pcnt=(new) hi_len-1.
  - When pcnt==0 and en=0: next state=IDLE.
  - clk_slow is low for exactly lo_len cycles. The period is hi_len+lo_len.
- en deassertion:
  - en is sampled only in IDLE and at the end of LOW.
  - Dropping en during HIGH completes the HIGH and LOW phases before entering IDLE. No truncated pulse is produced.
- Phase lengths:
  - Zero lengths saturate to 1 at capture time.
  - Minimum period is 2 cycles (hi=lo=1): clk_slow toggles every cycle, and rise/fall alternate every cycle.
- Config handshake:
  - The transfer occurs when cfg_valid && cfg_ready at a clock edge.
  - The transfer captures cfg_hi/cfg_lo into a shadow register and sets pend=1.
  - cfg_ready = !pend.
  - Shadow is applied at the next LOW→HIGH boundary, or on the next cycle if state=IDLE. pend clears in the same cycle the shadow is applied.
  - cfg_ready is therefore 0 for at least one cycle after every transfer.
  - A transfer in the final LOW cycle (pcnt==0) is not used for that boundary. It applies at the following boundary.
- Simultaneous events:
  - A cfg transfer in IDLE together with en=1: the HIGH phase starts with the old hi_len. The new values apply from the next boundary.
  - cfg_valid held with cfg_ready=0 has no effect. Data must be held by the sender.
- rise and fall are never both 1 in the same cycle. rise equals the output of an edge detector sampling clk_slow on clk.
- busy=1 in HIGH and LOW.

Test Plan:
- Reset with default parameters, en=1 from cycle 2 → clk_slow=0 in cycles 0–2; clk_slow=1,rise=1 in cycle 3; the waveform then toggles every cycle; period_cnt=4 after 8 cycles of running.
- cfg hi=3, lo=5 applied in IDLE, then en=1 → clk_slow high 3 cycles and low 5 cycles repeating; rise every 8 cycles; fall exactly 3 cycles after each rise.
- Running hi=3, lo=5; cfg hi=1, lo=2 transferred mid-HIGH → current period stays 3/5; cfg_ready=0 until the boundary; next period is 1/2; cfg_ready=1 in the cycle after application.
- Running hi=4, lo=4; en dropped in the 2nd HIGH cycle → HIGH lasts 4 cycles, LOW lasts 4 cycles, then IDLE with busy=0; no further rise strobe.
- cfg hi=0, lo=0 → behaves as 1/1 (period 2); PCNT_W=8 run for 256 periods → period_cnt wraps to 0.
- rst_l pulsed low mid-HIGH with a pending cfg → outputs clear asynchronously; after release, cfg_ready=1 and the waveform restarts with DEFAULT_HI/DEFAULT_LO.

Source files
------------

// File: rtl/slow_clock_gen.sv
// Programmable slow clock with registered rise/fall strobes; outputs change one cycle after the deciding edge.
// Config is a valid/ready slot that stays full (cfg_ready=0) until its values are applied at a period boundary.
module slow_clock_gen #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PCNT_W     = 8,
  parameter int unsigned DEFAULT_HI = 1,
  parameter int unsigned DEFAULT_LO = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_hi,
  input  logic [CNT_W-1:0]  cfg_lo,
  output logic              clk_slow,
  output logic              rise,
  output logic              fall,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_RST_HI = (DEFAULT_HI == 0) ? L_ONE : CNT_W'(DEFAULT_HI);
  localparam logic [CNT_W-1:0] L_RST_LO = (DEFAULT_LO == 0) ? L_ONE : CNT_W'(DEFAULT_LO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_pcnt;
  logic [CNT_W-1:0]    r_hi_len;
  logic [CNT_W-1:0]    r_lo_len;
  logic [CNT_W-1:0]    r_sh_hi;
  logic [CNT_W-1:0]    r_sh_lo;
  logic                r_pend;
  logic                r_clk_slow;
  logic                r_rise;
  logic                r_fall;
  logic [PCNT_W-1:0]   r_period_cnt;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_pcnt_nxt;
  logic [CNT_W-1:0]    w_hi_nxt;
  logic [CNT_W-1:0]    w_lo_nxt;
  logic [CNT_W-1:0]    w_sh_hi_nxt;
  logic [CNT_W-1:0]    w_sh_lo_nxt;
  logic                w_pend_nxt;
  logic                w_clk_nxt;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic [PCNT_W-1:0]   w_per_nxt;
  logic                w_start;
  logic                w_apply;
  logic [CNT_W-1:0]    w_hi_eff;

  // Zero-length phases are clamped when captured so the counters never underflow.
  function automatic logic [CNT_W-1:0] sat1(input logic [CNT_W-1:0] v);
    return (v == '0) ? L_ONE : v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_hi_nxt    = r_hi_len;
    w_lo_nxt    = r_lo_len;
    w_sh_hi_nxt = r_sh_hi;
    w_sh_lo_nxt = r_sh_lo;
    w_pend_nxt  = r_pend;
    w_clk_nxt   = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_per_nxt   = r_period_cnt;
    w_start     = 1'b0;

    unique case (r_state)
      ST_IDLE: w_start = en;
      ST_HIGH: begin
        w_clk_nxt = 1'b1;
        if (r_pcnt == '0) begin
          w_state_nxt = ST_LOW;
          w_clk_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
          w_pcnt_nxt  = r_lo_len - L_ONE;
        end else begin
          w_pcnt_nxt  = r_pcnt - L_ONE;
        end
      end
      ST_LOW: begin
        if (r_pcnt != '0) begin
          w_pcnt_nxt = r_pcnt - L_ONE;
        end else if (en) begin
          w_start = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Shadow lands only at a period boundary or while idle, never mid-period.
    w_apply  = r_pend && ((r_state == ST_IDLE) || w_start);
    w_hi_eff = w_apply ? r_sh_hi : r_hi_len;
    if (w_apply) begin
      w_hi_nxt   = r_sh_hi;
      w_lo_nxt   = r_sh_lo;
      w_pend_nxt = 1'b0;
    end

    if (w_start) begin
      w_state_nxt = ST_HIGH;
      w_clk_nxt   = 1'b1;
      w_rise_nxt  = 1'b1;
      w_per_nxt   = r_period_cnt + PCNT_W'(1);
      w_pcnt_nxt  = w_hi_eff - L_ONE;
    end

    // A transfer cannot coincide with an apply: it needs the slot empty.
    if (cfg_valid && !r_pend) begin
      w_sh_hi_nxt = sat1(cfg_hi);
      w_sh_lo_nxt = sat1(cfg_lo);
      w_pend_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= ST_IDLE;
      r_pcnt       <= '0;
      r_hi_len     <= L_RST_HI;
      r_lo_len     <= L_RST_LO;
      r_sh_hi      <= L_RST_HI;
      r_sh_lo      <= L_RST_LO;
      r_pend       <= 1'b0;
      r_clk_slow   <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_hi_len     <= w_hi_nxt;
      r_lo_len     <= w_lo_nxt;
      r_sh_hi      <= w_sh_hi_nxt;
      r_sh_lo      <= w_sh_lo_nxt;
      r_pend       <= w_pend_nxt;
      r_clk_slow   <= w_clk_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_period_cnt <= w_per_nxt;
    end
  end

  assign cfg_ready  = !r_pend;
  assign clk_slow   = r_clk_slow;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = (r_state != ST_IDLE);
  assign period_cnt = r_period_cnt;

endmodule
